// File: rtl/lsu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : lsu_rr_scheduler
// Purpose  : Round-robin scheduler sharing one data-memory port among the
//            LSUs of a core. One request is captured at a time, issued with a
//            valid/ready handshake, and (for reads) the single outstanding
//            response is routed back. Each completed transaction gives the
//            issuing LSU a one-cycle req_ack pulse.
// Ports    : clk, reset (async, active-high)
//            req_valid/req_write/req_addr/req_data  per-LSU request inputs
//            req_ack, resp_data                     per-LSU completion/read data
//            mem_valid/mem_write/mem_addr/mem_data  registered memory request
//            mem_ready, mem_resp_valid, mem_resp_data  memory controller side
//            busy                                   state != IDLE
// Options  : LSU_SCHED_PERF_EN adds perf_grants[15:0] and perf_stall[15:0]
//            saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_rr_scheduler #(
  parameter int NUM_REQUESTERS = 64,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int ID_WIDTH       = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] req_valid,
  input  logic [NUM_REQUESTERS-1:0] req_write,
  input  logic [ADDR_WIDTH-1:0]     req_addr [NUM_REQUESTERS],
  input  logic [DATA_WIDTH-1:0]     req_data [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] req_ack,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic                      mem_valid,
  output logic                      mem_write,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_data,
  input  logic                      mem_ready,
  input  logic                      mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]     mem_resp_data,
`ifdef LSU_SCHED_PERF_EN
  output logic [15:0]               perf_grants,
  output logic [15:0]               perf_stall,
`endif
  output logic                      busy
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_RESP = 2'd2
  } state_t;

  localparam logic [ID_WIDTH:0]   c_num_req = (ID_WIDTH+1)'(NUM_REQUESTERS);
  localparam logic [ID_WIDTH-1:0] c_last_id = ID_WIDTH'(NUM_REQUESTERS - 1);

  state_t                    state_q;
  logic [ID_WIDTH-1:0]       rr_ptr_q;
  logic [ID_WIDTH-1:0]       id_q;
  logic [NUM_REQUESTERS-1:0] req_ack_q;
  logic [DATA_WIDTH-1:0]     resp_data_q;
  logic                      mem_valid_q;
  logic                      mem_write_q;
  logic [ADDR_WIDTH-1:0]     mem_addr_q;
  logic [DATA_WIDTH-1:0]     mem_data_q;

  logic                      win_found_d;
  logic [ID_WIDTH-1:0]       win_id_d;
  logic [ID_WIDTH-1:0]       rr_ptr_d;
  logic [NUM_REQUESTERS-1:0] ack_vec_d;
  logic [NUM_REQUESTERS-1:0] eligible_d;
  logic [ID_WIDTH:0]         cand_d;

  // Rotating priority search starting at rr_ptr. An LSU being acked this
  // cycle still has req_valid high, so it is masked out to avoid a re-grant.
  always_comb begin
    win_found_d = 1'b0;
    win_id_d    = '0;
    cand_d      = '0;
    eligible_d  = req_valid & ~req_ack_q;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      cand_d = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(i);
      if (cand_d >= c_num_req) begin
        cand_d = cand_d - c_num_req;
      end
      if (!win_found_d && eligible_d[cand_d[ID_WIDTH-1:0]]) begin
        win_found_d = 1'b1;
        win_id_d    = cand_d[ID_WIDTH-1:0];
      end
    end
  end

  // Completion helpers: one-hot ack for the captured ID and the pointer
  // that hands priority to the LSU just after it.
  always_comb begin
    ack_vec_d = '0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      ack_vec_d[i] = (id_q == ID_WIDTH'(i));
    end
    rr_ptr_d = (id_q == c_last_id) ? '0 : id_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      req_ack_q   <= '0;
      resp_data_q <= '0;
      mem_valid_q <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
    end else begin
      req_ack_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            id_q        <= win_id_d;
            mem_write_q <= req_write[win_id_d];
            mem_addr_q  <= req_addr[win_id_d];
            mem_data_q  <= req_data[win_id_d];
            mem_valid_q <= 1'b1;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // mem_valid is always high here; outputs hold until accepted.
          if (mem_ready) begin
            mem_valid_q <= 1'b0;
            if (mem_write_q) begin
              req_ack_q <= ack_vec_d;
              rr_ptr_q  <= rr_ptr_d;
              state_q   <= S_IDLE;
            end else begin
              state_q   <= S_WAIT_RESP;
            end
          end
        end
        S_WAIT_RESP: begin
          if (mem_resp_valid) begin
            resp_data_q <= mem_resp_data;
            req_ack_q   <= ack_vec_d;
            rr_ptr_q    <= rr_ptr_d;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ack   = req_ack_q;
  assign resp_data = resp_data_q;
  assign mem_valid = mem_valid_q;
  assign mem_write = mem_write_q;
  assign mem_addr  = mem_addr_q;
  assign mem_data  = mem_data_q;
  assign busy      = (state_q != S_IDLE);

`ifdef LSU_SCHED_PERF_EN
  logic [15:0] perf_grants_q;
  logic [15:0] perf_stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_grants_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      if ((state_q == S_IDLE) && win_found_d && (perf_grants_q != 16'hFFFF)) begin
        perf_grants_q <= perf_grants_q + 16'd1;
      end
      if ((((state_q == S_ISSUE) && !mem_ready) || (state_q == S_WAIT_RESP)) &&
          (perf_stall_q != 16'hFFFF)) begin
        perf_stall_q <= perf_stall_q + 16'd1;
      end
    end
  end

  assign perf_grants = perf_grants_q;
  assign perf_stall  = perf_stall_q;
`endif

endmodule
`default_nettype wire
